// File: rtl/mmio_bus_fabric_if.sv
// ---------------------------------------------------------------------------
// mmio_bus_fabric_if
//   Bundles the core-side request/response signals and the shared slave-side
//   bus of the MMIO fabric.
//
//   Core side : m_req, m_write, m_addr, m_wdata -> fabric
//               m_rdata, m_ready, m_err         <- fabric
//   Slave side: s_sel, s_write, s_addr, s_wdata -> slaves
//               s_rdata (packed, slave i at [i*DATA_W +: DATA_W]),
//               s_ready (one bit per slave)     <- slaves
//
//   modport slave  : the fabric's view. It answers the core and drives the
//                    slave bus.
//   modport master : the environment's view. This is the core plus the slave
//                    devices, and it sees the fabric from the outside.
// ---------------------------------------------------------------------------
interface mmio_bus_fabric_if #(
    parameter int NSLAVES = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic                      m_req;
    logic                      m_write;
    logic [ADDR_W-1:0]         m_addr;
    logic [DATA_W-1:0]         m_wdata;
    logic [DATA_W-1:0]         m_rdata;
    logic                      m_ready;
    logic                      m_err;

    logic [NSLAVES-1:0]        s_sel;
    logic                      s_write;
    logic [ADDR_W-1:0]         s_addr;
    logic [DATA_W-1:0]         s_wdata;
    logic [NSLAVES*DATA_W-1:0] s_rdata;
    logic [NSLAVES-1:0]        s_ready;

    modport slave (
        input  m_req, m_write, m_addr, m_wdata, s_rdata, s_ready,
        output m_rdata, m_ready, m_err, s_sel, s_write, s_addr, s_wdata
    );

    modport master (
        output m_req, m_write, m_addr, m_wdata, s_rdata, s_ready,
        input  m_rdata, m_ready, m_err, s_sel, s_write, s_addr, s_wdata
    );
endinterface

// File: rtl/mmio_bus_fabric.sv
// ---------------------------------------------------------------------------
// mmio_bus_fabric
//   Memory-mapped interconnect between the core data port and NSLAVES slave
//   regions. The address is decoded against a base/mask pair for each slave.
//   When several slaves match, the lowest index wins. The selected slave is
//   held until it raises s_ready. A watchdog forces an error response when
//   the slave does not answer within TIMEOUT cycles. An unmapped address also
//   produces an error response. Every errored access updates err_addr and
//   err_count, and err_count saturates.
//
// Ports
//   clock      system clock, all state on posedge
//   reset_n    asynchronous active-low reset
//   bus        mmio_bus_fabric_if.slave (core request/response + slave bus)
//   err_addr   address of the most recent errored access
//   err_count  saturating count of errored accesses
// ---------------------------------------------------------------------------
module mmio_bus_fabric #(
    parameter int                          NSLAVES    = 4,
    parameter int                          ADDR_W     = 32,
    parameter int                          DATA_W     = 32,
    parameter logic [NSLAVES*ADDR_W-1:0]   SLAVE_BASE = '0,
    parameter logic [NSLAVES*ADDR_W-1:0]   SLAVE_MASK = '0,
    parameter int                          TIMEOUT    = 255,
    parameter logic [DATA_W-1:0]           ERR_DATA   = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic                clock,
    input  logic                reset_n,
    mmio_bus_fabric_if.slave    bus,
    output logic [ADDR_W-1:0]   err_addr,
    output logic [7:0]          err_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [NSLAVES-1:0]  sel_reg, sel_next;
    logic                write_reg, write_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic                ready_reg, ready_next;
    logic                err_reg, err_next;
    logic [7:0]          cnt_reg, cnt_next;
    logic [ADDR_W-1:0]   err_addr_reg, err_addr_next;
    logic [7:0]          err_count_reg, err_count_next;

    // ---------------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------------
    logic [NSLAVES-1:0]  hit;
    logic [NSLAVES-1:0]  win;

    for (genvar gi = 0; gi < NSLAVES; gi++) begin : g_decode
        assign hit[gi] = (bus.m_addr & SLAVE_MASK[gi*ADDR_W +: ADDR_W])
                         == SLAVE_BASE[gi*ADDR_W +: ADDR_W];
    end

    // hit & -hit isolates the lowest set bit, so the lowest index wins on overlap.
    assign win = hit & (~hit + NSLAVES'(1));

    // ---------------------------------------------------------------------
    // Selected-slave response. Only the slave we are driving is sampled,
    // so s_ready and s_rdata from other slaves are ignored.
    // ---------------------------------------------------------------------
    logic                sel_ready;
    logic [DATA_W-1:0]   sel_rdata;

    assign sel_ready = |(bus.s_ready & sel_reg);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (sel_reg[i]) begin
                sel_rdata = sel_rdata | bus.s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Saturating increment of the error counter.
    logic [7:0] err_count_inc;
    assign err_count_inc = (err_count_reg == 8'hFF) ? err_count_reg : err_count_reg + 8'd1;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            sel_reg       <= '0;
            write_reg     <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            ready_reg     <= 1'b0;
            err_reg       <= 1'b0;
            cnt_reg       <= '0;
            err_addr_reg  <= '0;
            err_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            sel_reg       <= sel_next;
            write_reg     <= write_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            rdata_reg     <= rdata_next;
            ready_reg     <= ready_next;
            err_reg       <= err_next;
            cnt_reg       <= cnt_next;
            err_addr_reg  <= err_addr_next;
            err_count_reg <= err_count_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state / output logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        sel_next       = sel_reg;
        write_next     = write_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        rdata_next     = rdata_reg;
        ready_next     = 1'b0;
        err_next       = err_reg;
        cnt_next       = cnt_reg;
        err_addr_next  = err_addr_reg;
        err_count_next = err_count_reg;

        case (state_reg)
            IDLE: begin
                if (bus.m_req) begin
                    write_next = bus.m_write;
                    addr_next  = bus.m_addr;
                    wdata_next = bus.m_wdata;
                    if (|hit) begin
                        sel_next   = win;
                        cnt_next   = '0;
                        state_next = ACCESS;
                    end else begin
                        // Unmapped: answer with an error right away. No slave is touched.
                        sel_next       = '0;
                        rdata_next     = ERR_DATA;
                        err_next       = 1'b1;
                        ready_next     = 1'b1;
                        err_addr_next  = bus.m_addr;
                        err_count_next = err_count_inc;
                        state_next     = RESP;
                    end
                end
            end

            ACCESS: begin
                cnt_next = cnt_reg + 8'd1;
                if (sel_ready) begin
                    // Writes return zero so m_rdata never carries stale slave data.
                    rdata_next = write_reg ? '0 : sel_rdata;
                    err_next   = 1'b0;
                    sel_next   = '0;
                    ready_next = 1'b1;
                    state_next = RESP;
                end else if (cnt_reg == 8'(TIMEOUT - 1)) begin
                    sel_next       = '0;
                    rdata_next     = ERR_DATA;
                    err_next       = 1'b1;
                    ready_next     = 1'b1;
                    err_addr_next  = addr_reg;
                    err_count_next = err_count_inc;
                    state_next     = RESP;
                end
            end

            RESP: begin
                // m_ready goes low through the ready_next default. m_rdata keeps its value.
                err_next   = 1'b0;
                state_next = IDLE;
            end

            default: begin
                sel_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.m_rdata = rdata_reg;
    assign bus.m_ready = ready_reg;
    assign bus.m_err   = err_reg;
    assign bus.s_sel   = sel_reg;
    assign bus.s_write = write_reg;
    assign bus.s_addr  = addr_reg;
    assign bus.s_wdata = wdata_reg;
    assign err_addr    = err_addr_reg;
    assign err_count   = err_count_reg;

endmodule
